// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the load/store unit (port 0)
// and the debug/DMA master (port 1); one access at a time with an acknowledge timeout.
module data_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [1:0]  req_we_i,
  input  logic [5:0]  req_funct3_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic [1:0]  resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [2:0]  mem_funct3_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        last_owner;
  logic        owner;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  timer;

  logic [1:0]  grant;
  logic        win;

  // The port that did not win last time takes a tie; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    win   = 1'b0;
    if (!rst_i && state == S_IDLE && |req_valid_i) begin
      if (&req_valid_i) win = ~last_owner;
      else              win = req_valid_i[1];
      grant[win] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      timer      <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            owner      <= win;
            last_owner <= win;
            we_q       <= req_we_i[win];
            funct3_q   <= win ? req_funct3_i[5:3] : req_funct3_i[2:0];
            addr_q     <= win ? req_addr_i[63:32] : req_addr_i[31:0];
            wdata_q    <= win ? req_wdata_i[63:32] : req_wdata_i[31:0];
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= 8'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // An acknowledge arriving in the expiry cycle still completes normally.
          if (mem_ack_i) begin
            rdata_q <= mem_rdata_i;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (timer == TMO_LAST) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = grant;
  assign mem_req_o    = (state == S_ISSUE);
  assign mem_we_o     = we_q;
  assign mem_funct3_o = funct3_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign resp_valid_o = (state == S_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_err_o   = (state == S_RESP) & err_q;
  assign resp_rdata_o = rdata_q;
  assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: arbitration order, access sequencing, timeout and reset.
module tb_data_mem_arbiter;

  localparam int TMO = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_we_i;
  logic [5:0]  req_funct3_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [1:0]  resp_valid_o;
  logic        resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_funct3_o(mem_funct3_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Runs one access from an IDLE cycle to the IDLE cycle after its response.
  // ack_at: WAIT cycle (1-based) in which mem_ack_i is pulsed; 0 means never.
  task automatic access(input string tag, input logic [1:0] valid, input logic [1:0] valid_after,
                        input int exp_port, input int ack_at, input logic [31:0] mdata,
                        input logic exp_we, input logic [2:0] exp_f3, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic exp_err, input logic [31:0] exp_rdata);
    int w;
    logic [1:0] onehot;
    onehot = (exp_port == 1) ? 2'b10 : 2'b01;
    req_valid_i = valid;
    #1;
    check({tag, "_ready"}, 32'(req_ready_o), 32'(onehot));
    tick();
    req_valid_i = valid_after;
    #1;
    check({tag, "_issue_req"}, 32'(mem_req_o), 32'd1);
    check({tag, "_issue_ready"}, 32'(req_ready_o), 32'd0);
    check({tag, "_addr"}, mem_addr_o, exp_addr);
    check({tag, "_we"}, 32'(mem_we_o), 32'(exp_we));
    check({tag, "_funct3"}, 32'(mem_funct3_o), 32'(exp_f3));
    if (exp_we) check({tag, "_wdata"}, mem_wdata_o, exp_wdata);
    tick();
    check({tag, "_wait_req"}, 32'(mem_req_o), 32'd0);
    check({tag, "_wait_busy"}, 32'(busy_o), 32'd1);
    w = 1;
    while (w <= TMO + 5) begin
      if (w == ack_at) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mdata;
      end
      tick();
      mem_ack_i = 1'b0;
      if (resp_valid_o != 2'b00) break;
      w++;
    end
    check({tag, "_wait_cycles"}, 32'(w), 32'((ack_at != 0) ? ack_at : TMO));
    check({tag, "_resp_valid"}, 32'(resp_valid_o), 32'(onehot));
    check({tag, "_resp_err"}, 32'(resp_err_o), 32'(exp_err));
    check({tag, "_resp_rdata"}, resp_rdata_o, exp_rdata);
    tick();
    check({tag, "_resp_done"}, 32'(resp_valid_o), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = 2'b11;
    req_we_i     = 2'b10;
    req_funct3_i = {3'b001, 3'b010};
    req_addr_i   = {32'h0000_0004, 32'h0000_0010};
    req_wdata_i  = {32'h0000_0005, 32'h1234_5678};
    mem_ack_i    = 1'b0;
    mem_rdata_i  = 32'd0;
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    tick();
    tick();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_resp", 32'(resp_valid_o), 32'd0);
    check("rst_memreq", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    req_valid_i = 2'b00;
    rst_i = 1'b0;
    tick();
    check("idle_ready", 32'(req_ready_o), 32'd0);

    // p0 read, ack two cycles after mem_req_o
    access("p0rd", 2'b01, 2'b00, 0, 2, 32'hDEAD_BEEF, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    // p1 write
    access("p1wr", 2'b10, 2'b00, 1, 1, 32'hCAFE_0001, 1'b1, 3'b001, 32'h4, 32'h5, 1'b0, 32'hCAFE_0001);
    // no ack: timeout error with zero data
    mem_rdata_i = 32'hFFFF_FFFF;
    access("tmo", 2'b01, 2'b00, 0, 0, 32'h0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h0);
    // late ack in IDLE is ignored
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check("late_ack_busy", 32'(busy_o), 32'd0);
    check("late_ack_resp", 32'(resp_valid_o), 32'd0);
    access("after_tmo", 2'b01, 2'b00, 0, 3, 32'h0BAD_F00D, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0BAD_F00D);
    // ack in the final timeout cycle wins
    access("last_ack", 2'b01, 2'b00, 0, TMO, 32'h5555_AAAA, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h5555_AAAA);

    // reset while waiting for the acknowledge
    req_valid_i = 2'b10;
    tick();
    req_valid_i = 2'b00;
    tick();
    tick();
    check("mid_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    req_valid_i = 2'b11;
    #1;
    check("mid_rst_ready", 32'(req_ready_o), 32'd0);
    tick();
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_resp", 32'(resp_valid_o), 32'd0);
    check("mid_rst_addr", mem_addr_o, 32'd0);
    req_valid_i = 2'b00;
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check("mid_ack_busy", 32'(busy_o), 32'd0);
    check("mid_ack_resp", 32'(resp_valid_o), 32'd0);

    // both valid after reset: p0 first, then p1, twice
    access("both_a0", 2'b11, 2'b10, 0, 1, 32'h1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1);
    access("both_a1", 2'b10, 2'b00, 1, 1, 32'h2, 1'b1, 3'b001, 32'h4, 32'h5, 1'b0, 32'h2);
    access("both_b0", 2'b11, 2'b10, 0, 1, 32'h3, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h3);
    access("both_b1", 2'b10, 2'b00, 1, 1, 32'h4, 1'b1, 3'b001, 32'h4, 32'h5, 1'b0, 32'h4);

    // p0 held valid, p1 re-requests after each grant: strict alternation
    access("alt0", 2'b11, 2'b11, 0, 1, 32'h10, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h10);
    access("alt1", 2'b11, 2'b11, 1, 1, 32'h11, 1'b1, 3'b001, 32'h4, 32'h5, 1'b0, 32'h11);
    access("alt2", 2'b11, 2'b11, 0, 1, 32'h12, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h12);
    access("alt3", 2'b11, 2'b00, 1, 1, 32'h13, 1'b1, 3'b001, 32'h4, 32'h5, 1'b0, 32'h13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
